mmio_gpio_bank: RTL and testbench

MMIO_GPIO_BANK -- requirements
Module: mmio_gpio_bank

---
 rtl/mmio_gpio_bank.sv | 127 ++++++++++++
 tb/tb_mmio_gpio_bank.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_gpio_bank.sv
// rtl/mmio_gpio_bank.sv - memory-mapped GPIO bank with edge flags and optional edge interrupt
//
// Purpose: CHANNELS independent WIDTH-bit GPIO channels behind a 4-word-per-channel
// register window starting at BASE_ADDR. Per channel: 0 DATA_IN (RO, synchronized io_in),
// 1 DATA_OUT (RW, drives io_out), 2 EDGE_FLAGS (RO, write-1-to-clear, set on rising edge),
// 3 EDGE_MASK (RW, interrupt enables).
// Build option: define GPIO_IRQ_EN to enable EDGE_MASK and irq; otherwise EDGE_MASK reads 0,
// ignores writes and irq is tied to 0.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-low reset
//   addr    - word address
//   din     - write data (only din[WIDTH-1:0] used)
//   we      - write enable
//   dout    - registered read data, one cycle after addr
//   hit     - registered, high when dout came from this block
//   io_in   - asynchronous inputs, channel c at [c*WIDTH +: WIDTH]
//   io_out  - registered outputs, same packing
//   irq     - registered level interrupt
module mmio_gpio_bank #(
  parameter int          CHANNELS  = 2,
  parameter int          WIDTH     = 4,
  parameter logic [15:0] BASE_ADDR = 16'hFFF0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               addr,
  input  logic [15:0]               din,
  input  logic                      we,
  output logic [15:0]               dout,
  output logic                      hit,
  input  logic [CHANNELS*WIDTH-1:0] io_in,
  output logic [CHANNELS*WIDTH-1:0] io_out,
  output logic                      irq
);

  localparam int N = CHANNELS * WIDTH;

  logic [N-1:0]  sync1, sync2, prev, data_out, flags;
  logic [N-1:0]  rise, data_out_nxt, flag_clr;
  logic [15:0]   win_off, rd_data;
  logic          in_win;
  logic [1:0]    ch_sel, reg_sel;
  logic          unused_din;

`ifdef GPIO_IRQ_EN
  logic [N-1:0]  mask, mask_nxt;
`endif

  // Offset is computed with wraparound; the >= check rejects addresses below the window.
  assign win_off    = addr - BASE_ADDR;
  assign in_win     = (addr >= BASE_ADDR) && (win_off < 16'(4 * CHANNELS));
  assign ch_sel     = win_off[3:2];
  assign reg_sel    = addr[1:0];
  assign rise       = sync2 & ~prev;
  assign io_out     = data_out;
  assign unused_din = ^din;

  always_comb begin
    data_out_nxt = data_out;
    flag_clr     = '0;
    rd_data      = '0;
`ifdef GPIO_IRQ_EN
    mask_nxt     = mask;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_win && ch_sel == 2'(c)) begin
        // Read path always sees pre-write contents, so a same-cycle write returns the old value.
        case (reg_sel)
          2'd0: rd_data[WIDTH-1:0] = sync2[c*WIDTH +: WIDTH];
          2'd1: rd_data[WIDTH-1:0] = data_out[c*WIDTH +: WIDTH];
          2'd2: rd_data[WIDTH-1:0] = flags[c*WIDTH +: WIDTH];
`ifdef GPIO_IRQ_EN
          2'd3: rd_data[WIDTH-1:0] = mask[c*WIDTH +: WIDTH];
`endif
          default: ;
        endcase
        if (we) begin
          case (reg_sel)
            2'd1: data_out_nxt[c*WIDTH +: WIDTH] = din[WIDTH-1:0];
            2'd2: flag_clr[c*WIDTH +: WIDTH]     = din[WIDTH-1:0];
`ifdef GPIO_IRQ_EN
            2'd3: mask_nxt[c*WIDTH +: WIDTH]     = din[WIDTH-1:0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      data_out <= '0;
      flags    <= '0;
      dout     <= '0;
      hit      <= 1'b0;
    end else begin
      sync1    <= io_in;
      sync2    <= sync1;
      prev     <= sync2;
      data_out <= data_out_nxt;
      // Set after clear: a new edge wins over a simultaneous write-1-to-clear.
      flags    <= (flags & ~flag_clr) | rise;
      dout     <= rd_data;
      hit      <= in_win;
    end
  end

`ifdef GPIO_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      mask <= mask_nxt;
      irq  <= |(flags & mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// tb/tb_mmio_gpio_bank.sv - directed scoreboard bench for mmio_gpio_bank
module tb_mmio_gpio_bank;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] din;
  logic        we;
  logic [15:0] dout;
  logic        hit;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic        irq;

  int total;
  int bad;

  typedef struct {
    string       tag;
    logic [15:0] dout;
    logic        hit;
  } rd_exp_t;

  rd_exp_t sb[$];

  mmio_gpio_bank #(.CHANNELS(2), .WIDTH(4), .BASE_ADDR(16'hFFF0)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .din    (din),
    .we     (we),
    .dout   (dout),
    .hit    (hit),
    .io_in  (io_in),
    .io_out (io_out),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check();
    rd_exp_t x;
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      total--;
      x = sb.pop_front();
      chk({x.tag, ".dout"}, dout, x.dout);
      chk({x.tag, ".hit"}, {15'b0, hit}, {15'b0, x.hit});
    end
  endtask

  task automatic wr(logic [15:0] a, logic [15:0] d);
    addr = a; din = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(string tag, logic [15:0] a, logic [15:0] e, logic eh);
    addr = a; din = 16'h0; we = 1'b0;
    sb.push_back('{tag, e, eh});
    step();
    pop_check();
  endtask

  task automatic rw(string tag, logic [15:0] a, logic [15:0] d, logic [15:0] e);
    addr = a; din = d; we = 1'b1;
    sb.push_back('{tag, e, 1'b1});
    step();
    we = 1'b0;
    pop_check();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0; io_in = 8'h00; addr = 16'h0; din = 16'h0; we = 1'b0;

    // Reset overrides a simultaneous write.
    wr(16'hFFF1, 16'h000F);
    step();
    chk("rst_io_out", {8'h0, io_out}, 16'h0);
    chk("rst_irq", {15'b0, irq}, 16'h0);
    chk("rst_dout", dout, 16'h0);
    chk("rst_hit", {15'b0, hit}, 16'h0);
    reset = 1'b1;

    // DATA_OUT write drives io_out one edge later, upper din bits ignored.
    wr(16'hFFF1, 16'h00A5);
    chk("wr_io_out", {8'h0, io_out}, 16'h0005);
    rd("rd_fff1", 16'hFFF1, 16'h0005, 1'b1);

    // Channel 1 input rises: synchronized value and edge flag.
    io_in = 8'h20;
    step(); step(); step();
    rd("din_fff4", 16'hFFF4, 16'h0002, 1'b1);
    rd("flag_fff6", 16'hFFF6, 16'h0002, 1'b1);
    rd("flag_fff2", 16'hFFF2, 16'h0000, 1'b1);

    // Mask and interrupt.
    wr(16'hFFF7, 16'h0002);
    step();
    chk("irq_set", {15'b0, irq}, {15'b0, IRQ_EN});
    rd("mask_fff7", 16'hFFF7, IRQ_EN ? 16'h0002 : 16'h0000, 1'b1);

    // W1C clears flag, irq follows a cycle later.
    wr(16'hFFF6, 16'h0002);
    rd("flag_clr", 16'hFFF6, 16'h0000, 1'b1);
    chk("irq_clr", {15'b0, irq}, 16'h0);

    // Sustained high input does not re-set the flag.
    step(); step();
    rd("flag_sustain", 16'hFFF6, 16'h0000, 1'b1);

    // New edge coincident with W1C: flag stays set.
    io_in = 8'h00;
    step(); step(); step(); step();
    io_in = 8'h20;
    step(); step();
    wr(16'hFFF6, 16'h0002);
    rd("flag_edge_wins", 16'hFFF6, 16'h0002, 1'b1);

    // Outside the window and writes to DATA_IN.
    rd("rd_fff8", 16'hFFF8, 16'h0000, 1'b0);
    rd("rd_1234", 16'h1234, 16'h0000, 1'b0);
    wr(16'hFFF8, 16'hFFFF);
    wr(16'h1234, 16'hFFFF);
    wr(16'hFFEF, 16'hFFFF);
    wr(16'hFFF0, 16'h000F);
    chk("oow_io_out", {8'h0, io_out}, 16'h0005);
    rd("oow_fff5", 16'hFFF5, 16'h0000, 1'b1);
    rd("oow_fff0", 16'hFFF0, 16'h0000, 1'b1);
    rd("oow_fff6", 16'hFFF6, 16'h0002, 1'b1);

    // Same-cycle read and write returns pre-write value.
    rw("rw_fff5", 16'hFFF5, 16'hFFF3, 16'h0000);
    rd("rw_after", 16'hFFF5, 16'h0003, 1'b1);
    chk("rw_io_out", {8'h0, io_out}, 16'h0035);

    // Reset mid-operation with outputs set and a flag pending.
    wr(16'hFFF1, 16'h000F);
    chk("pre_rst_io_out", {8'h0, io_out}, 16'h003F);
    reset = 1'b0;
    addr = 16'hFFF1; din = 16'h0009; we = 1'b1;
    step();
    we = 1'b0;
    chk("mid_rst_io_out", {8'h0, io_out}, 16'h0);
    chk("mid_rst_dout", dout, 16'h0);
    chk("mid_rst_hit", {15'b0, hit}, 16'h0);
    chk("mid_rst_irq", {15'b0, irq}, 16'h0);
    step();
    reset = 1'b1;

    // Input held high through reset: one legal edge, three cycles after release.
    rd("post_rst_flag0", 16'hFFF6, 16'h0000, 1'b1);
    step(); step();
    rd("post_rst_flag1", 16'hFFF6, 16'h0002, 1'b1);
    rd("post_rst_mask", 16'hFFF7, 16'h0000, 1'b1);
    wr(16'hFFF6, 16'h000F);
    step(); step();
    rd("post_rst_once", 16'hFFF6, 16'h0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
